// File: rtl/regfile_access_ctrl.sv
// Access sequencer for the 32x32 CPU register file: one strobe per cycle,
// decode/writeback arbitration with RAW hazard priority, anti-starvation and power-on clear.
module regfile_access_ctrl #(
    parameter int unsigned RESET_CYCLES  = 2,
    parameter int unsigned MAX_WR_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic [5:0]  rd_opcode,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    input  logic [4:0]  rd_reg3,
    input  logic [31:0] rd_imm,
    output logic        rd_ack,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [5:0]  wr_opcode,
    input  logic [4:0]  wr_reg,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        reg_read,
    output logic        reg_write,
    output logic        reg_reset,
    output logic [5:0]  opcode,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  reg3,
    output logic [31:0] imm,
    output logic [31:0] write_data,
    output logic        busy
);

    localparam logic [3:0] RST_CNT    = 4'(RESET_CYCLES);
    localparam logic [3:0] MAX_STREAK = 4'(MAX_WR_STREAK);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  init_cnt, init_cnt_next;
    logic [3:0]  streak, streak_next;
    logic        hazard, grant_wr;

    logic        rd_ack_next, rd_valid_next, wr_ack_next;
    logic        reg_read_next, reg_write_next, reg_reset_next, busy_next;
    logic [5:0]  opcode_next;
    logic [4:0]  reg1_next, reg2_next, reg3_next;
    logic [31:0] imm_next, write_data_next;

    // reg3 is only a source operand for non-zero opcodes with bit 4 clear
    assign hazard = wr_req && ((wr_reg == rd_reg1) || (wr_reg == rd_reg2) ||
                    ((rd_opcode != 6'd0) && !rd_opcode[4] && (wr_reg == rd_reg3)));
    assign grant_wr = wr_req && (!rd_req || hazard || (streak < MAX_STREAK));

    always_comb begin
        state_next      = state;
        init_cnt_next   = init_cnt;
        streak_next     = streak;
        rd_ack_next     = 1'b0;
        rd_valid_next   = 1'b0;
        wr_ack_next     = 1'b0;
        reg_read_next   = 1'b0;
        reg_write_next  = 1'b0;
        reg_reset_next  = 1'b0;
        opcode_next     = opcode;
        reg1_next       = reg1;
        reg2_next       = reg2;
        reg3_next       = reg3;
        imm_next        = imm;
        write_data_next = write_data;

        case (state)
            S_INIT: begin
                if (init_cnt != 4'd0) begin
                    reg_reset_next = 1'b1;
                    init_cnt_next  = init_cnt - 4'd1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (grant_wr) begin
                    state_next      = S_WRITE;
                    reg_write_next  = 1'b1;
                    wr_ack_next     = 1'b1;
                    opcode_next     = wr_opcode;
                    reg1_next       = wr_reg;
                    write_data_next = wr_data;
                    // A hazard write leaves the streak alone so the waiting read is not penalised
                    if (rd_req && !hazard) begin
                        streak_next = (streak >= MAX_STREAK) ? MAX_STREAK : streak + 4'd1;
                    end else if (!rd_req) begin
                        streak_next = 4'd0;
                    end
                end else if (rd_req) begin
                    state_next    = S_READ;
                    reg_read_next = 1'b1;
                    rd_ack_next   = 1'b1;
                    opcode_next   = rd_opcode;
                    reg1_next     = rd_reg1;
                    reg2_next     = rd_reg2;
                    reg3_next     = rd_reg3;
                    imm_next      = rd_imm;
                    streak_next   = 4'd0;
                end
            end
            S_READ: begin
                state_next    = S_IDLE;
                rd_valid_next = 1'b1;
            end
            S_WRITE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_INIT;
            init_cnt   <= RST_CNT;
            streak     <= 4'd0;
            rd_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            wr_ack     <= 1'b0;
            reg_read   <= 1'b0;
            reg_write  <= 1'b0;
            reg_reset  <= 1'b0;
            busy       <= 1'b1;
            opcode     <= 6'd0;
            reg1       <= 5'd0;
            reg2       <= 5'd0;
            reg3       <= 5'd0;
            imm        <= 32'd0;
            write_data <= 32'd0;
        end else begin
            state      <= state_next;
            init_cnt   <= init_cnt_next;
            streak     <= streak_next;
            rd_ack     <= rd_ack_next;
            rd_valid   <= rd_valid_next;
            wr_ack     <= wr_ack_next;
            reg_read   <= reg_read_next;
            reg_write  <= reg_write_next;
            reg_reset  <= reg_reset_next;
            busy       <= busy_next;
            opcode     <= opcode_next;
            reg1       <= reg1_next;
            reg2       <= reg2_next;
            reg3       <= reg3_next;
            imm        <= imm_next;
            write_data <= write_data_next;
        end
    end

endmodule
